axi_lite_slv_ctrl: RTL
======================

Name: axi_lite_slv_ctrl

Overview:
- AXI4-Lite slave protocol engine. It sits directly upstream of the register-space address decoder and read mux.
- Terminates the five AXI4-Lite channels and latches address, data and strobes.
- Issues single-cycle slv_reg_wren / slv_reg_rden pulses to the decoder, then returns the decoder's registered read data with RVALID one cycle after the rden pulse.
- Flags accesses to unmapped regions with SLVERR.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 12, byte address width; bits [11:8] select the region.
- C_NUM_REGIONS, 5, number of mapped regions; region index >= C_NUM_REGIONS is unmapped.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- S_AXI_AWADDR  in  ADDR  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  DATA  write data.
- S_AXI_WSTRB  in  DATA/8  write strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  DATA  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- slv_awaddr  out  ADDR  latched write address to decoder.
- slv_wdata  out  DATA  latched write data.
- slv_wstrb  out  DATA/8  latched write strobes.
- slv_araddr  out  ADDR  latched read address.
- slv_reg_wren  out  1  one-cycle write pulse.
- slv_reg_rden  out  1  one-cycle read pulse.
- slv_rdata  in  DATA  decoder registered read data; valid the cycle after slv_reg_rden.

Behaviour:
- Reset: every output is 0 and both FSMs go to IDLE. Reset is asynchronous, so an in-flight transaction is dropped and no pulse is issued after reset.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_EXEC, W_RESP:
  - W_IDLE: AWREADY=WREADY=1. AW and W are captured independently.
  - Both captured in the same cycle -> W_EXEC. AW only -> W_DATA (AWREADY=0, WREADY=1). W only -> W_ADDR.
  - W_EXEC, one cycle: slv_reg_wren=1 if region is mapped, else 0. BRESP is set to OKAY or SLVERR. Next state W_RESP.
  - W_RESP: BVALID=1 and held, with BRESP stable, until BREADY. Then W_IDLE with AWREADY/WREADY re-asserted on the following cycle.
  - Write accept to wren: exactly 1 cycle after the last of AW/W handshakes. Throughput is at most 1 write per 3 cycles.
- Read FSM, states R_IDLE, R_EXEC, R_WAIT, R_RESP:
  - R_IDLE: ARREADY=1. On handshake, latch ARADDR into slv_araddr -> R_EXEC.
  - R_EXEC: slv_reg_rden=1 if mapped -> R_WAIT.
  - R_WAIT: decoder output settles; capture slv_rdata into the RDATA register, or 0 if unmapped. Set RRESP -> R_RESP.
  - R_RESP: RVALID=1 and held, with RDATA/RRESP stable, until RREADY -> R_IDLE.
  - Latency: AR handshake at cycle N, rden at N+1, RDATA captured at the end of N+2, RVALID high from N+3.
- Read and write channels are fully independent. Simultaneous wren and rden pulses are legal, because the decoder uses separate address buses.
- Latched slv_* values remain stable from capture until the next capture on the same channel.
- BREADY or RREADY held high in advance: the response completes in its first valid cycle.
- VALID deasserted by the master after its handshake has no effect.
- Region decode: mapped iff addr[11:8] < C_NUM_REGIONS.

Decomposition:
- Shared package/include holds:
  - AXI response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - FSM state encodings.
  - The region field position [11:8], shared with the existing region base definitions.
- One natural sub-module: axi_lite_rd_ch, containing the read FSM, the RDATA capture and the region check. The write FSM stays in the top.

Test Plan:
- AW and W in the same cycle, addr 0x104, data 0xA5A5_0001, strb 0xF -> wren pulses 1 cycle later with slv_awaddr=0x104 and slv_wdata=0xA5A5_0001; BVALID next cycle, BRESP=00.
- W two cycles before AW -> WREADY low after W capture; wren 1 cycle after AW handshake; slv_wdata holds the earlier W value.
- Read 0x200 with decoder returning 0x1234_5678 after rden -> RVALID at N+3, RDATA=0x1234_5678, RRESP=00. RREADY held low for 4 cycles -> RVALID/RDATA stable.
- Read 0xF00 (unmapped) -> no rden, RDATA=0, RRESP=10. Write 0x500 -> no wren, BRESP=10.
- Concurrent read 0x000 and write 0x300 issued the same cycle -> wren and rden pulse in the same cycle; both responses correct.
- Assert S_AXI_ARESET during W_RESP and R_WAIT -> all outputs 0 immediately; no further wren/rden; next transaction completes normally.

Source files
------------

// File: rtl/axi_lite_slv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_slv_ctrl_pkg
// Definitions shared by the AXI4-Lite slave protocol engine:
//   - AXI response codes
//   - write and read FSM state encodings
//   - position of the region field inside the byte address, which must match
//     the region base definitions used by the register-space decoder
//   - region_mapped(): tells whether a region index is backed by registers
// -----------------------------------------------------------------------------
package axi_lite_slv_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address bits [11:8] select one of up to 16 regions.
  localparam int REGION_LSB = 8;
  localparam int REGION_MSB = 11;
  localparam int REGION_W   = REGION_MSB - REGION_LSB + 1;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_EXEC,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_EXEC,
    R_WAIT,
    R_RESP
  } r_state_t;

  // A region is mapped when its index is below the number of mapped regions.
  function automatic logic region_mapped(input logic [REGION_W-1:0] region,
                                         input int unsigned num_regions);
    return 32'(region) < num_regions;
  endfunction

endpackage

// File: rtl/axi_lite_rd_ch.sv
// -----------------------------------------------------------------------------
// axi_lite_rd_ch
// AXI4-Lite read channel: accepts one read address at a time, issues a single
// cycle rden pulse to the decoder (mapped regions only), captures the decoder's
// registered read data one cycle later and holds RVALID/RDATA/RRESP until the
// master takes the response.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   araddr/arvalid/arready        AR channel
//   rdata/rresp/rvalid/rready     R channel
//   slv_araddr      latched read address to the decoder
//   slv_reg_rden    one-cycle read pulse to the decoder
//   slv_rdata       decoder registered read data, valid the cycle after rden
// -----------------------------------------------------------------------------
module axi_lite_rd_ch
  import axi_lite_slv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int NUM_REGIONS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ADDR_WIDTH-1:0] slv_araddr,
  output logic                  slv_reg_rden,
  input  logic [DATA_WIDTH-1:0] slv_rdata
);

  r_state_t              r_state_reg, r_state_next;
  logic                  arready_reg, arready_next;
  logic                  rvalid_reg, rvalid_next;
  logic [1:0]            rresp_reg, rresp_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
  logic                  ar_hs;
  logic                  ar_mapped;
  logic                  rden;

  assign ar_mapped = region_mapped(araddr_reg[REGION_MSB:REGION_LSB], NUM_REGIONS);

  always_comb begin
    r_state_next = r_state_reg;
    arready_next = arready_reg;
    rvalid_next  = rvalid_reg;
    rresp_next   = rresp_reg;
    rdata_next   = rdata_reg;
    araddr_next  = araddr_reg;
    rden         = 1'b0;
    // arready is registered, so it stays low for the first cycle after reset.
    ar_hs        = arvalid & arready_reg;

    case (r_state_reg)
      R_IDLE: begin
        arready_next = 1'b1;
        if (ar_hs) begin
          araddr_next  = araddr;
          arready_next = 1'b0;
          r_state_next = R_EXEC;
        end
      end
      R_EXEC: begin
        rden         = ar_mapped;
        r_state_next = R_WAIT;
      end
      R_WAIT: begin
        // The decoder's registered output is valid now; unmapped reads
        // return zero instead of whatever the decoder happens to drive.
        rdata_next   = ar_mapped ? slv_rdata : '0;
        rresp_next   = ar_mapped ? RESP_OKAY : RESP_SLVERR;
        rvalid_next  = 1'b1;
        r_state_next = R_RESP;
      end
      R_RESP: begin
        if (rready) begin
          rvalid_next  = 1'b0;
          arready_next = 1'b1;
          r_state_next = R_IDLE;
        end
      end
      default: begin
        r_state_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= 2'b00;
      rdata_reg   <= '0;
      araddr_reg  <= '0;
    end else begin
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rresp_reg   <= rresp_next;
      rdata_reg   <= rdata_next;
      araddr_reg  <= araddr_next;
    end
  end

  assign arready      = arready_reg;
  assign rvalid       = rvalid_reg;
  assign rresp        = rresp_reg;
  assign rdata        = rdata_reg;
  assign slv_araddr   = araddr_reg;
  assign slv_reg_rden = rden;

endmodule

// File: rtl/axi_lite_slv_ctrl.sv
// -----------------------------------------------------------------------------
// axi_lite_slv_ctrl
// AXI4-Lite slave protocol engine placed in front of the register-space
// address decoder and read mux. Terminates the five AXI4-Lite channels,
// latches address/data/strobes, issues single-cycle write and read pulses to
// the decoder and flags accesses to unmapped regions with SLVERR.
// The write path lives here; the read path is in axi_lite_rd_ch. The two are
// fully independent, so wren and rden may pulse in the same cycle.
// C_S_AXI_DATA_WIDTH must be 32 or 64.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET      clock, asynchronous active-high reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B* write address / data / response channels
//   S_AXI_AR*, S_AXI_R*           read address / data channels
//   slv_awaddr/slv_wdata/slv_wstrb latched write address, data, strobes
//   slv_araddr                    latched read address
//   slv_reg_wren/slv_reg_rden     one-cycle write/read pulses to the decoder
//   slv_rdata                     decoder read data, valid the cycle after rden
// -----------------------------------------------------------------------------
module axi_lite_slv_ctrl
  import axi_lite_slv_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_NUM_REGIONS      = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   slv_awaddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] slv_wstrb,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   slv_araddr,
  output logic                            slv_reg_wren,
  output logic                            slv_reg_rden,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   slv_rdata
);

  localparam int STRB_WIDTH = C_S_AXI_DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t                      w_state_reg, w_state_next;
  logic                          awready_reg, awready_next;
  logic                          wready_reg, wready_next;
  logic                          bvalid_reg, bvalid_next;
  logic [1:0]                    bresp_reg, bresp_next;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0]         wstrb_reg, wstrb_next;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          aw_mapped;
  logic                          wren;

  assign aw_mapped = region_mapped(awaddr_reg[REGION_MSB:REGION_LSB], C_NUM_REGIONS);

  always_comb begin
    w_state_next = w_state_reg;
    awready_next = awready_reg;
    wready_next  = wready_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    wren         = 1'b0;
    // Ready flags are registered, so a handshake can only happen in a state
    // that has the matching ready raised; this also keeps the latched values
    // stable until the next capture on the same channel.
    aw_hs        = S_AXI_AWVALID & awready_reg;
    w_hs         = S_AXI_WVALID & wready_reg;

    if (aw_hs) begin
      awaddr_next = S_AXI_AWADDR;
    end
    if (w_hs) begin
      wdata_next = S_AXI_WDATA;
      wstrb_next = S_AXI_WSTRB;
    end

    case (w_state_reg)
      W_IDLE: begin
        awready_next = 1'b1;
        wready_next  = 1'b1;
        if (aw_hs && w_hs) begin
          awready_next = 1'b0;
          wready_next  = 1'b0;
          w_state_next = W_EXEC;
        end else if (aw_hs) begin
          awready_next = 1'b0;
          w_state_next = W_DATA;
        end else if (w_hs) begin
          wready_next  = 1'b0;
          w_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        if (aw_hs) begin
          awready_next = 1'b0;
          w_state_next = W_EXEC;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wready_next  = 1'b0;
          w_state_next = W_EXEC;
        end
      end
      W_EXEC: begin
        wren         = aw_mapped;
        bresp_next   = aw_mapped ? RESP_OKAY : RESP_SLVERR;
        bvalid_next  = 1'b1;
        w_state_next = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_next  = 1'b0;
          awready_next = 1'b1;
          wready_next  = 1'b1;
          w_state_next = W_IDLE;
        end
      end
      default: begin
        w_state_next = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign slv_awaddr    = awaddr_reg;
  assign slv_wdata     = wdata_reg;
  assign slv_wstrb     = wstrb_reg;
  assign slv_reg_wren  = wren;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  axi_lite_rd_ch #(
    .DATA_WIDTH  (C_S_AXI_DATA_WIDTH),
    .ADDR_WIDTH  (C_S_AXI_ADDR_WIDTH),
    .NUM_REGIONS (C_NUM_REGIONS)
  ) u_rd_ch (
    .clk          (S_AXI_ACLK),
    .rst          (S_AXI_ARESET),
    .araddr       (S_AXI_ARADDR),
    .arvalid      (S_AXI_ARVALID),
    .arready      (S_AXI_ARREADY),
    .rdata        (S_AXI_RDATA),
    .rresp        (S_AXI_RRESP),
    .rvalid       (S_AXI_RVALID),
    .rready       (S_AXI_RREADY),
    .slv_araddr   (slv_araddr),
    .slv_reg_rden (slv_reg_rden),
    .slv_rdata    (slv_rdata)
  );

endmodule
